// File: rtl/palette_fader_if.sv
// Signal bundle for palette_fader: pixel stream, brightness/fade control and the
// palette memory port. The design side uses the slave modport.
interface palette_fader_if #(
    parameter int PAL_BITS   = 5,
    parameter int COLOR_BITS = 4,
    parameter int CHAN_W     = 8
);
    localparam int IW = PAL_BITS + COLOR_BITS;

    logic                pix_valid;
    logic [IW-1:0]       pix_index;
    logic                enable;
    logic [CHAN_W-1:0]   red;
    logic [CHAN_W-1:0]   green;
    logic [CHAN_W-1:0]   blue;
    logic                pix_out_valid;
    logic                transparent;

    logic                fade_start;
    logic [CHAN_W-1:0]   fade_target;
    logic [15:0]         fade_rate;
    logic                fade_done;
    logic                fading;
    logic [CHAN_W-1:0]   brightness;
    logic                bright_load;
    logic [CHAN_W-1:0]   bright_value;

    logic                memenable;
    logic [IW:0]         memaddr;
    logic                memwrite;
    logic [2*CHAN_W-1:0] writedata;
    logic [2*CHAN_W-1:0] memdata;

    modport master (
        output pix_valid, pix_index, enable,
        output fade_start, fade_target, fade_rate, bright_load, bright_value,
        output memenable, memaddr, memwrite, writedata,
        input  red, green, blue, pix_out_valid, transparent,
        input  fade_done, fading, brightness, memdata
    );

    modport slave (
        input  pix_valid, pix_index, enable,
        input  fade_start, fade_target, fade_rate, bright_load, bright_value,
        input  memenable, memaddr, memwrite, writedata,
        output red, green, blue, pix_out_valid, transparent,
        output fade_done, fading, brightness, memdata
    );
endinterface

// File: rtl/palette_fader.sv
// Palette lookup with a two-stage pixel pipeline, brightness scaling and a
// stepwise brightness fader; the palette is also exposed as a 2*CHAN_W memory.
module palette_fader #(
    parameter int PAL_BITS   = 5,
    parameter int COLOR_BITS = 4,
    parameter int CHAN_W     = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    palette_fader_if.slave   bus
);
    localparam int IW      = PAL_BITS + COLOR_BITS;
    localparam int ENTRIES = 1 << IW;
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_FADING = 1'b1;
    localparam logic [CHAN_W-1:0] CHAN_ZERO = {CHAN_W{1'b0}};
    localparam logic [CHAN_W-1:0] CHAN_ONE  = {{(CHAN_W-1){1'b0}}, 1'b1};

    // Entry layout is {blue, green, red}.
    logic [3*CHAN_W-1:0] pal_mem_r [ENTRIES];
    logic [IW-1:0]       mem_entry_s;
    logic                mem_sel_s;

    logic [3*CHAN_W-1:0] s1_color_r;
    logic                s1_valid_r;
    logic                s1_transp_r;
    logic                s1_enable_r;

    logic [0:0]          state_r;
    logic [15:0]         step_cnt_r;
    logic [15:0]         rate_r;
    logic [CHAN_W-1:0]   target_r;
    logic [CHAN_W-1:0]   bright_r;
    logic                done_r;

    assign mem_entry_s    = bus.memaddr[IW:1];
    assign mem_sel_s      = bus.memaddr[0];
    assign bus.brightness = bright_r;
    assign bus.fading     = (state_r == ST_FADING);
    assign bus.fade_done  = done_r;

    // Scale by (b+1)/2^CHAN_W so that full brightness returns c unchanged.
    function automatic logic [CHAN_W-1:0] scale_chan(input logic [CHAN_W-1:0] c,
                                                     input logic [CHAN_W-1:0] b);
        logic [CHAN_W:0]   bp1;
        logic [2*CHAN_W:0] prod;
        bp1  = {1'b0, b} + {{CHAN_W{1'b0}}, 1'b1};
        prod = {{(CHAN_W+1){1'b0}}, c} * {{CHAN_W{1'b0}}, bp1};
        return prod[2*CHAN_W-1:CHAN_W];
    endfunction

    // Palette storage writes; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (bus.memenable && bus.memwrite) begin
            if (mem_sel_s) begin
                pal_mem_r[mem_entry_s][3*CHAN_W-1:2*CHAN_W] <= bus.writedata[CHAN_W-1:0];
            end else begin
                pal_mem_r[mem_entry_s][2*CHAN_W-1:0] <= bus.writedata;
            end
        end
    end

    // Memory read port, holds its value while memenable is low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.memdata <= {(2*CHAN_W){1'b0}};
        end else if (bus.memenable) begin
            if (mem_sel_s) begin
                bus.memdata <= {CHAN_ZERO, pal_mem_r[mem_entry_s][3*CHAN_W-1:2*CHAN_W]};
            end else begin
                bus.memdata <= pal_mem_r[mem_entry_s][2*CHAN_W-1:0];
            end
        end
    end

    // Pixel stage 1: palette lookup (read-first against a same-cycle write).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_color_r  <= {(3*CHAN_W){1'b0}};
            s1_valid_r  <= 1'b0;
            s1_transp_r <= 1'b0;
            s1_enable_r <= 1'b0;
        end else begin
            s1_color_r  <= pal_mem_r[bus.pix_index];
            s1_valid_r  <= bus.pix_valid;
            s1_transp_r <= (bus.pix_index[COLOR_BITS-1:0] == {COLOR_BITS{1'b0}});
            s1_enable_r <= bus.enable;
        end
    end

    // Pixel stage 2: brightness scaling and output gating.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.red           <= CHAN_ZERO;
            bus.green         <= CHAN_ZERO;
            bus.blue          <= CHAN_ZERO;
            bus.pix_out_valid <= 1'b0;
            bus.transparent   <= 1'b0;
        end else begin
            if (s1_enable_r) begin
                bus.red   <= scale_chan(s1_color_r[CHAN_W-1:0], bright_r);
                bus.green <= scale_chan(s1_color_r[2*CHAN_W-1:CHAN_W], bright_r);
                bus.blue  <= scale_chan(s1_color_r[3*CHAN_W-1:2*CHAN_W], bright_r);
            end else begin
                bus.red   <= CHAN_ZERO;
                bus.green <= CHAN_ZERO;
                bus.blue  <= CHAN_ZERO;
            end
            bus.pix_out_valid <= s1_valid_r;
            bus.transparent   <= s1_transp_r;
        end
    end

    // Fade controller; a direct load always wins over a fade request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            step_cnt_r <= 16'd0;
            rate_r     <= 16'd0;
            target_r   <= CHAN_ZERO;
            bright_r   <= CHAN_ZERO;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (bus.bright_load) begin
                bright_r   <= bus.bright_value;
                state_r    <= ST_IDLE;
                step_cnt_r <= 16'd0;
            end else if (bus.fade_start) begin
                target_r   <= bus.fade_target;
                rate_r     <= bus.fade_rate;
                step_cnt_r <= 16'd0;
                state_r    <= ST_FADING;
            end else if (state_r == ST_FADING) begin
                if (bright_r == target_r) begin
                    state_r    <= ST_IDLE;
                    done_r     <= 1'b1;
                    step_cnt_r <= 16'd0;
                end else if (step_cnt_r == rate_r) begin
                    step_cnt_r <= 16'd0;
                    if (bright_r < target_r) begin
                        bright_r <= bright_r + CHAN_ONE;
                    end else begin
                        bright_r <= bright_r - CHAN_ONE;
                    end
                end else begin
                    step_cnt_r <= step_cnt_r + 16'd1;
                end
            end else begin
                step_cnt_r <= 16'd0;
            end
        end
    end
endmodule

// File: tb/tb_palette_fader.sv
// Self-checking bench for palette_fader: directed and randomized steps against
// a behavioural palette/brightness model.
module tb_palette_fader;
    localparam int PAL_BITS   = 5;
    localparam int COLOR_BITS = 4;
    localparam int CHAN_W     = 8;
    localparam int ENTRIES    = 512;

    logic clk = 1'b0;
    logic reset_n;
    int   checks   = 0;
    int   failures = 0;

    int pal_r [ENTRIES];
    int pal_g [ENTRIES];
    int pal_b [ENTRIES];
    int bright_m;

    palette_fader_if #(.PAL_BITS(PAL_BITS), .COLOR_BITS(COLOR_BITS), .CHAN_W(CHAN_W)) bus ();
    palette_fader #(.PAL_BITS(PAL_BITS), .COLOR_BITS(COLOR_BITS), .CHAN_W(CHAN_W)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_ch(input int c, input int b, input bit en);
        return en ? (c * (b + 1)) / 256 : 0;
    endfunction

    task automatic mem_wr(input int entry, input int sel, input int data);
        bus.memenable = 1'b1;
        bus.memwrite  = 1'b1;
        bus.memaddr   = 10'(entry * 2 + sel);
        bus.writedata = 16'(data);
        tick();
        bus.memenable = 1'b0;
        bus.memwrite  = 1'b0;
        if (sel == 0) begin
            pal_r[entry] = data % 256;
            pal_g[entry] = (data / 256) % 256;
        end else begin
            pal_b[entry] = data % 256;
        end
    endtask

    task automatic mem_rd_chk(input string tag, input int entry, input int sel);
        int exp;
        bus.memenable = 1'b1;
        bus.memwrite  = 1'b0;
        bus.memaddr   = 10'(entry * 2 + sel);
        tick();
        bus.memenable = 1'b0;
        exp = (sel == 1) ? pal_b[entry] : pal_g[entry] * 256 + pal_r[entry];
        chk(tag, 32'(bus.memdata), 32'(exp));
    endtask

    task automatic load_bright(input int v);
        bus.bright_load  = 1'b1;
        bus.bright_value = 8'(v);
        tick();
        bus.bright_load = 1'b0;
        bright_m = v;
        chk("bright_load", 32'(bus.brightness), 32'(v));
    endtask

    task automatic pixel_chk(input string tag, input int idx, input bit en);
        bus.pix_valid = 1'b1;
        bus.pix_index = 9'(idx);
        bus.enable    = en;
        tick();
        bus.pix_valid = 1'b0;
        bus.enable    = 1'b0;
        chk({tag, "_lat"}, 32'(bus.pix_out_valid), 32'd0);
        tick();
        chk({tag, "_r"}, 32'(bus.red),   32'(exp_ch(pal_r[idx], bright_m, en)));
        chk({tag, "_g"}, 32'(bus.green), 32'(exp_ch(pal_g[idx], bright_m, en)));
        chk({tag, "_b"}, 32'(bus.blue),  32'(exp_ch(pal_b[idx], bright_m, en)));
        chk({tag, "_v"}, 32'(bus.pix_out_valid), 32'd1);
        chk({tag, "_t"}, 32'(bus.transparent), 32'((idx % 16) == 0));
    endtask

    initial begin
        int done_cnt;
        int entry;
        int b_exp;
        reset_n = 1'b1;
        bus.pix_valid = 1'b0; bus.pix_index = 9'd0; bus.enable = 1'b0;
        bus.fade_start = 1'b0; bus.fade_target = 8'd0; bus.fade_rate = 16'd0;
        bus.bright_load = 1'b0; bus.bright_value = 8'd0;
        bus.memenable = 1'b0; bus.memaddr = 10'd0; bus.memwrite = 1'b0; bus.writedata = 16'd0;
        bright_m = 0;
        #1 reset_n = 1'b0;
        #1;
        chk("rst_red", 32'(bus.red), 32'd0);
        chk("rst_pov", 32'(bus.pix_out_valid), 32'd0);
        chk("rst_memdata", 32'(bus.memdata), 32'd0);
        chk("rst_bright", 32'(bus.brightness), 32'd0);
        chk("rst_fading", 32'(bus.fading), 32'd0);
        chk("rst_done", 32'(bus.fade_done), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Basic lookup at full, half and zero brightness; upper byte of blue write ignored
        mem_wr(19, 0, 16'h40C0);
        mem_wr(19, 1, 16'hAB20);
        load_bright(255);
        pixel_chk("full", 19, 1'b1);
        chk("full_r_const", 32'(bus.red), 32'hC0);
        load_bright(127);
        pixel_chk("half", 19, 1'b1);
        chk("half_r_const", 32'(bus.red), 32'h60);
        load_bright(0);
        pixel_chk("zero", 19, 1'b1);
        load_bright(255);
        pixel_chk("en_low", 19, 1'b0);
        mem_wr(32, 0, 16'h1234);
        mem_wr(32, 1, 16'h0056);
        pixel_chk("transp", 32, 1'b1);

        // Memory readback and hold
        mem_rd_chk("rd_even", 19, 0);
        mem_rd_chk("rd_odd", 19, 1);
        tick();
        chk("rd_hold", 32'(bus.memdata), 32'h0020);

        // Randomized palette contents, brightness and enable
        for (int i = 0; i < 24; i++) begin
            entry = $urandom_range(0, ENTRIES - 1);
            mem_wr(entry, 0, $urandom_range(0, 65535));
            mem_wr(entry, 1, $urandom_range(0, 65535));
            load_bright($urandom_range(0, 255));
            pixel_chk("rand", entry, ($urandom_range(0, 3) != 0));
        end

        // Read-first: pixel and write to entry 5 in the same cycle
        mem_wr(5, 0, 16'h1122);
        mem_wr(5, 1, 16'h0033);
        load_bright(255);
        bus.pix_valid = 1'b1; bus.pix_index = 9'd5; bus.enable = 1'b1;
        bus.memenable = 1'b1; bus.memwrite = 1'b1; bus.memaddr = 10'd10; bus.writedata = 16'h5566;
        tick();
        bus.pix_valid = 1'b0; bus.enable = 1'b0; bus.memenable = 1'b0; bus.memwrite = 1'b0;
        tick();
        chk("rf_old_r", 32'(bus.red), 32'h22);
        chk("rf_old_g", 32'(bus.green), 32'h11);
        pal_r[5] = 32'h66;
        pal_g[5] = 32'h55;
        pixel_chk("rf_new", 5, 1'b1);
        mem_rd_chk("rf_odd", 5, 1);

        // Fade 0 -> 4 at rate 2: one step every 3 clocks
        load_bright(0);
        bus.fade_target = 8'd4; bus.fade_rate = 16'd2; bus.fade_start = 1'b1;
        tick();
        bus.fade_start = 1'b0;
        chk("fade_fading0", 32'(bus.fading), 32'd1);
        done_cnt = 0;
        for (int t = 1; t <= 16; t++) begin
            tick();
            b_exp = (t / 3 > 4) ? 4 : t / 3;
            chk("fade_b", 32'(bus.brightness), 32'(b_exp));
            chk("fade_fading", 32'(bus.fading), 32'(t < 13));
            chk("fade_done", 32'(bus.fade_done), 32'(t == 13));
            if (bus.fade_done) done_cnt++;
        end
        chk("fade_done_cnt", 32'(done_cnt), 32'd1);

        // Retarget mid-fade reverses direction
        bus.fade_target = 8'd10; bus.fade_rate = 16'd0; bus.fade_start = 1'b1;
        load_bright(0);
        bus.fade_start = 1'b1;
        tick();
        bus.fade_start = 1'b0;
        for (int t = 1; t <= 3; t++) begin
            tick();
            chk("up_b", 32'(bus.brightness), 32'(t));
        end
        bus.fade_target = 8'd0; bus.fade_start = 1'b1;
        tick();
        bus.fade_start = 1'b0;
        chk("retgt_b", 32'(bus.brightness), 32'd3);
        for (int t = 1; t <= 3; t++) begin
            tick();
            chk("down_b", 32'(bus.brightness), 32'(3 - t));
            chk("down_done", 32'(bus.fade_done), 32'd0);
        end
        tick();
        chk("down_fin_done", 32'(bus.fade_done), 32'd1);
        chk("down_fin_fading", 32'(bus.fading), 32'd0);

        // Target equal to current brightness
        bus.fade_target = 8'd0; bus.fade_rate = 16'd7; bus.fade_start = 1'b1;
        tick();
        bus.fade_start = 1'b0;
        chk("same_fading", 32'(bus.fading), 32'd1);
        chk("same_done0", 32'(bus.fade_done), 32'd0);
        tick();
        chk("same_done1", 32'(bus.fade_done), 32'd1);
        chk("same_b", 32'(bus.brightness), 32'd0);
        tick();
        chk("same_done2", 32'(bus.fade_done), 32'd0);

        // bright_load beats a simultaneous fade_start and aborts the fade
        load_bright(32);
        bus.fade_target = 8'hFF; bus.fade_rate = 16'd5; bus.fade_start = 1'b1;
        tick();
        bus.fade_start = 1'b0;
        repeat (4) tick();
        bus.bright_load = 1'b1; bus.bright_value = 8'h80;
        bus.fade_start = 1'b1; bus.fade_target = 8'h10;
        tick();
        bus.bright_load = 1'b0; bus.fade_start = 1'b0;
        bright_m = 128;
        chk("prio_b", 32'(bus.brightness), 32'h80);
        chk("prio_fading", 32'(bus.fading), 32'd0);
        for (int t = 0; t < 4; t++) begin
            tick();
            chk("prio_done", 32'(bus.fade_done), 32'd0);
            chk("prio_hold", 32'(bus.brightness), 32'h80);
        end

        // Reset mid-fade with pixels in flight
        mem_rd_chk("pre_rst_rd", 19, 0);
        bus.fade_target = 8'd0; bus.fade_rate = 16'd0; bus.fade_start = 1'b1;
        tick();
        bus.fade_start = 1'b0;
        bus.pix_valid = 1'b1; bus.pix_index = 9'd19; bus.enable = 1'b1;
        repeat (2) tick();
        chk("pre_rst_pov", 32'(bus.pix_out_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("arst_red", 32'(bus.red), 32'd0);
        chk("arst_green", 32'(bus.green), 32'd0);
        chk("arst_blue", 32'(bus.blue), 32'd0);
        chk("arst_pov", 32'(bus.pix_out_valid), 32'd0);
        chk("arst_memdata", 32'(bus.memdata), 32'd0);
        chk("arst_fading", 32'(bus.fading), 32'd0);
        chk("arst_bright", 32'(bus.brightness), 32'd0);
        tick();
        chk("rst_hold_pov", 32'(bus.pix_out_valid), 32'd0);
        reset_n = 1'b1;
        chk("rel_pov0", 32'(bus.pix_out_valid), 32'd0);
        tick();
        chk("rel_pov1", 32'(bus.pix_out_valid), 32'd0);
        chk("rel_fading", 32'(bus.fading), 32'd0);
        bus.pix_valid = 1'b0; bus.enable = 1'b0;
        tick();
        load_bright(255);
        pixel_chk("post_rst", 19, 1'b1);
        mem_rd_chk("post_rst_rd", 19, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/palette_fader.md
PALETTE_FADER -- requirements
Module: palette_fader

Interface
REQ-001 SHALL have parameter PAL_BITS, default 5, palette-select bits (2^PAL_BITS palettes).
REQ-002 SHALL have parameter COLOR_BITS, default 4, color-select bits (2^COLOR_BITS colors per palette).
REQ-003 SHALL have parameter CHAN_W, default 8, bits per color channel; IW = PAL_BITS+COLOR_BITS.
REQ-004 SHALL have ports clk in 1, clock; reset_n in 1, asynchronous active-low reset.
REQ-005 SHALL have ports pix_valid in 1; pix_index in IW (upper PAL_BITS = palette, lower COLOR_BITS = color); enable in 1, output gate.
REQ-006 SHALL have ports red, green, blue out CHAN_W each; pix_out_valid out 1; transparent out 1, color index 0.
REQ-007 SHALL have fade ports fade_start in 1 (pulse); fade_target in CHAN_W; fade_rate in 16, clocks per step; fade_done out 1; fading out 1; brightness out CHAN_W.
REQ-008 SHALL have direct-load ports bright_load in 1; bright_value in CHAN_W.
REQ-009 SHALL have memory ports memenable in 1; memaddr in IW+1; memwrite in 1; writedata in 2*CHAN_W; memdata out 2*CHAN_W.

Function
REQ-010 SHALL hold 2^IW color entries of 3*CHAN_W bits; contents not reset.
REQ-011 SHALL map memory word memaddr = {entry, sel}: sel=0 is {green, red}; sel=1 is {zeros, blue}.
REQ-012 SHALL, on memenable&memwrite, write the selected field at the clock edge; on sel=1, writedata upper CHAN_W bits are ignored.
REQ-013 SHALL return memdata one cycle after memenable; sel=1 reads return upper CHAN_W bits zero; memdata holds when memenable low.
REQ-014 SHALL have read-first behaviour: pixel read and memory write to the same entry in one cycle return old data.
REQ-015 SHALL have pixel pipeline latency 2: pix_index sampled cycle N, RGB/pix_out_valid/transparent valid at cycle N+2.
REQ-016 SHALL pass pix_valid and transparent (pix_index color field == 0) through the pipeline aligned with data.
REQ-017 SHALL compute each channel as (c * (brightness+1)) >> CHAN_W, product width 2*CHAN_W+1; brightness all-ones yields c exactly, 0 yields 0.
REQ-018 SHALL use the brightness value registered in stage 2; pix_out_valid still asserts for pixels gated to zero.
REQ-019 SHALL force RGB to 0 when enable (sampled with the index at cycle N) was low.
REQ-020 SHALL implement fade FSM states IDLE and FADING; fading=1 only in FADING.
REQ-021 SHALL, on fade_start, latch fade_target and fade_rate, clear the step counter, and enter FADING (also when already FADING: retarget, counter restart).
REQ-022 SHALL, in FADING, increment the step counter each clock; when counter == latched rate, step brightness by 1 toward target and clear the counter; fade_rate=0 steps every clock.
REQ-023 SHALL, when brightness == latched target in FADING, return to IDLE and pulse fade_done for exactly one cycle; fade_start with target == current brightness gives fade_done the following cycle, no brightness change.
REQ-024 SHALL, on bright_load, set brightness = bright_value next cycle, abort any fade to IDLE, no fade_done; bright_load has priority over simultaneous fade_start.
REQ-025 SHALL never let brightness wrap below 0 or above 2^CHAN_W-1.

Reset
REQ-026 SHALL, while reset_n low, asynchronously clear RGB, pix_out_valid, transparent, memdata, fade_done, fading, brightness to 0; FSM to IDLE; counter to 0.
REQ-027 SHALL abort a fade in progress on reset; in-flight pixels are discarded (pix_out_valid 0 for 2 cycles after release).

Verification
REQ-028 Write entry 0x013 {green,red}=0x40C0, blue=0x0020; bright_load 0xFF; pixel 0x013 -> two cycles later R=0xC0 G=0x40 B=0x20, transparent=0.
REQ-029 bright_value 0x7F, same entry -> R=0x60 G=0x20 B=0x10; bright_value 0x00 -> RGB 0, pix_out_valid=1.
REQ-030 From brightness 0, fade_start target 0x04 rate 2 -> brightness steps every 3 cycles, reaches 0x04 after 12 cycles, single fade_done pulse, fading low.
REQ-031 Mid-fade fade_start target 0x00 -> direction reverses; simultaneous bright_load 0x80 + fade_start -> brightness 0x80, IDLE, no fade_done.
REQ-032 Same-cycle pixel read and memory write to entry 0x005 -> pixel shows old color, next read new; odd-address read returns upper byte 0.
REQ-033 Assert reset_n low mid-fade with pixels in flight -> all outputs 0 immediately, palette contents preserved after release.
